// File: rtl/hex_display_scan_if.sv
// -----------------------------------------------------------------------------
// hex_display_scan_if
//
// Purpose : Groups the value-load strobe and the multiplexed 8-digit
//           seven-segment drive signals of hex_display_scan into one bundle.
//
// Signals :
//   load        staging strobe, one cycle wide, qualifies the three below
//   hex_value   eight hex nibbles, digit k = hex_value[4k+3:4k]
//   dp_in       decimal point per digit, 1 = lit
//   digit_en    per-digit enable, 1 = shown
//   an          anode drive, active-low, one-hot-low or all-high
//   seg         cathodes {g,f,e,d,c,b,a}, active-low
//   dp          decimal point cathode, active-low
//   frame_done  one-cycle pulse at each frame boundary
//   pending     a staged value is waiting for the next frame boundary
//
// Modports:
//   master  drives load/hex_value/dp_in/digit_en, observes the display side
//   slave   the scanner itself
// -----------------------------------------------------------------------------
interface hex_display_scan_if;
    logic        load;
    logic [31:0] hex_value;
    logic [7:0]  dp_in;
    logic [7:0]  digit_en;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;
    logic        pending;

    modport master (
        output load, hex_value, dp_in, digit_en,
        input  an, seg, dp, frame_done, pending
    );

    modport slave (
        input  load, hex_value, dp_in, digit_en,
        output an, seg, dp, frame_done, pending
    );
endinterface

// File: rtl/hex_display_scan.sv
// -----------------------------------------------------------------------------
// hex_display_scan
//
// Purpose : Time-multiplexed driver for an 8-digit common-anode seven-segment
//           display. A prescaler holds each digit for DIV_CNT cycles; the first
//           BLANK_CYCLES of every dwell keep all anodes off to avoid ghosting.
//           New values are staged on load and only copied to the display
//           shadow at a frame boundary, so a frame never mixes old and new data.
//
// Parameters:
//   DIV_CNT       ACLK cycles each digit is held (4 .. 2^20)
//   BLANK_CYCLES  all-anodes-off cycles at the start of each dwell
//                 (1 .. DIV_CNT-2)
//
// Ports:
//   ACLK    sole clock, rising edge
//   ARESET  asynchronous, active-high reset
//   bus     hex_display_scan_if.slave (load/hex_value/dp_in/digit_en in,
//           an/seg/dp/frame_done/pending out, all outputs registered)
//
// Build option:
//   HEX_LZB_EN  when defined, leading-zero blanking: digit k (k >= 1) is also
//               blanked when shadow nibbles k..7 are all zero. Digit 0 is
//               never blanked by this rule. Undefined: only digit_en applies.
// -----------------------------------------------------------------------------
module hex_display_scan #(
    parameter int DIV_CNT      = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    hex_display_scan_if.slave bus
);

    localparam int PRE_W = $clog2(DIV_CNT);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIV_CNT - 1);
    localparam logic [PRE_W-1:0] BLANK_THR = PRE_W'(BLANK_CYCLES);

    // Scan position
    logic [PRE_W-1:0] pre;
    logic [2:0]       idx;

    // Staging register (written by load) and display shadow (written only at
    // a frame boundary)
    logic [31:0] stg_hex;
    logic [7:0]  stg_dp;
    logic [7:0]  stg_en;
    logic [31:0] sh_hex;
    logic [7:0]  sh_dp;
    logic [7:0]  sh_en;
    logic        pending_q;

    // Registered outputs
    logic [7:0]  an_q;
    logic [6:0]  seg_q;
    logic        dp_q;
    logic        frame_done_q;

    // Active-low decode, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic       wrap;
    logic       boundary;
    logic [3:0] nibble;
    logic       lead_zero;
    logic       visible;

    always_comb begin
        // NOTE: every always_comb output gets a value on every path first,
        // otherwise synthesis infers a latch to hold the old value.
        lead_zero = 1'b0;
`ifdef HEX_LZB_EN
        // Nibbles idx..7 all zero means this digit is a leading zero
        lead_zero = (idx != 3'd0) && ((sh_hex >> {idx, 2'b00}) == 32'd0);
`endif
        wrap     = (pre == PRE_LAST);
        boundary = wrap && (idx == 3'd7);
        nibble   = sh_hex[{idx, 2'b00} +: 4];
        visible  = (pre >= BLANK_THR) && sh_en[idx] && !lead_zero;
    end

    // NOTE: staging and shadow are small flop banks, not RAM, so they are
    // reset along with the rest; a mid-frame reset must discard what is shown.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            pre          <= '0;
            idx          <= '0;
            stg_hex      <= '0;
            stg_dp       <= '0;
            stg_en       <= '0;
            sh_hex       <= '0;
            sh_dp        <= '0;
            sh_en        <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            an_q         <= 8'hFF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge state, regardless of statement order.
            if (wrap) begin
                pre <= '0;
                idx <= idx + 3'd1;
            end else begin
                pre <= pre + 1'b1;
            end

            if (bus.load) begin
                stg_hex <= bus.hex_value;
                stg_dp  <= bus.dp_in;
                stg_en  <= bus.digit_en;
            end

            // A load on the boundary cycle bypasses staging so the newest
            // value wins and nothing is left pending.
            if (boundary) begin
                if (bus.load) begin
                    sh_hex <= bus.hex_value;
                    sh_dp  <= bus.dp_in;
                    sh_en  <= bus.digit_en;
                end else if (pending_q) begin
                    sh_hex <= stg_hex;
                    sh_dp  <= stg_dp;
                    sh_en  <= stg_en;
                end
                pending_q <= 1'b0;
            end else if (bus.load) begin
                pending_q <= 1'b1;
            end

            frame_done_q <= boundary;
            an_q         <= visible ? ~(8'h01 << idx) : 8'hFF;
            seg_q        <= visible ? seg_decode(nibble) : 7'h7F;
            dp_q         <= visible ? ~sh_dp[idx] : 1'b1;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frame_done_q;
    assign bus.pending    = pending_q;

endmodule

// File: doc/hex_display_scan.md
HEX_DISPLAY_SCAN -- requirements
Module: hex_display_scan

Interface
REQ-001 Parameter DIV_CNT, default 100000: ACLK cycles each digit is held (dwell); legal range 4..2^20.
REQ-002 Parameter BLANK_CYCLES, default 4: anti-ghosting cycles at dwell start when all anodes are off; legal range 1..DIV_CNT-2.
REQ-003 ACLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 ARESET  in  1  asynchronous, active-high reset.
REQ-005 load  in  1  single-cycle strobe qualifying hex_value/dp_in/digit_en.
REQ-006 hex_value  in  32  eight hex nibbles; digit k = bits [4k+3:4k].
REQ-007 dp_in  in  8  decimal point per digit, 1 = lit.
REQ-008 digit_en  in  8  per-digit enable, 1 = shown.
REQ-009 an  out  8  anode drive, active-low, one-hot-low or all-high.
REQ-010 seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  out  1  decimal point cathode, active-low.
REQ-012 frame_done  out  1  one-cycle pulse at each frame boundary.
REQ-013 pending  out  1  staged value not yet displayed.

Function
REQ-014 Prescaler pre counts 0..DIV_CNT-1, wraps to 0; digit index idx (3 bits) increments mod 8 on pre = DIV_CNT-1.
REQ-015 Frame boundary = cycle with pre = DIV_CNT-1 and idx = 7.
REQ-016 On load, staging register captures {hex_value, dp_in, digit_en} and pending sets; multiple loads before a boundary: last wins.
REQ-017 At a frame boundary with pending = 1, staging copies to display shadow, pending clears.
REQ-018 load coincident with boundary: that load's value goes directly to shadow at the boundary; pending ends 0.
REQ-019 frame_done pulses for one cycle at every frame boundary, independent of pending.
REQ-020 Digit k visible when idx = k, pre >= BLANK_CYCLES, shadow digit_en[k] = 1; then an[k] = 0, others 1; else an = 8'hFF.
REQ-021 seg = active-low decode of shadow nibble idx: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E (hex); seg = 7F and dp = 1 whenever an = FF.
REQ-022 dp = ~shadow dp_in[idx] when digit visible.
REQ-023 an, seg, dp, frame_done, pending are registered: one ACLK latency from the pre/idx/shadow state they reflect.
REQ-024 Display never shows a mix of old and new shadow within one frame (tear-free).

Reset
REQ-025 ARESET asserts asynchronously: pre = 0, idx = 0, staging = 0, shadow = 0, pending = 0, frame_done = 0, an = FF, seg = 7F, dp = 1.
REQ-026 Reset mid-frame discards staged and shown values; scanning restarts at digit 0, pre = 0, on first edge after deassertion.

Configuration
REQ-027 Macro HEX_LZB_EN selects leading-zero blanking.
REQ-028 HEX_LZB_EN defined: digit k (k >= 1) is additionally blanked when shadow nibbles k..7 are all zero; digit 0 is never blanked by this rule.
REQ-029 HEX_LZB_EN undefined: only digit_en governs visibility; zero nibbles display "0".

Verification (DIV_CNT = 8, BLANK_CYCLES = 2)
REQ-030 Reset, no load -> an = FF, seg = 7F, dp = 1 for 3 frames; frame_done pulses every 64 cycles.
REQ-031 load hex_value = 76543210, dp_in = 01, digit_en = FF -> pending = 1 until next boundary; next frame digit 0: an = FE, seg = 40, dp = 0 for 6 cycles after 2 blank cycles; digit 3: an = F7, seg = 30.
REQ-032 Mid-frame load of 0000ABCD while 76543210 shown -> remainder of frame still shows 7..4 on digits 7..4; following frame shows A on digit 3 (seg = 08).
REQ-033 load asserted exactly at boundary with hex_value = FFFFFFFF -> pending stays 0; next frame all digits seg = 0E.
REQ-034 HEX_LZB_EN defined, load 0000000C, digit_en = FF -> only an = FE (seg = 46) ever asserted; undefined -> all 8 digits scanned, digits 7..1 seg = 40.
REQ-035 ARESET pulsed mid-digit 5 with 12345678 shown -> outputs immediately return to reset values; after release display stays blank until a new load and boundary.
